// File: rtl/node_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : node_sequencer_if                                              |
// | Desc    : Host/control bundle for node_sequencer; NODE_SEQ_PERF_EN adds  |
// |           the perf_cyc busy-cycle counter output.                        |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
interface node_sequencer_if #(
    parameter int ITER_W = 24
);
    logic              start;
    logic              abort;
    logic [ITER_W-1:0] iter_limit;
    logic              shift_req;
    logic              shift_ack;
    logic              opt_run;
    logic              dist_com_valid;
    logic [1:0]        dist_com_step;
    logic              exp_init;
    logic              exp_run;
    logic              exp_fin;
    logic              exch_run;
    logic              exch_odd;
    logic              distance_shift;
    logic              exchange_shift_d;
    logic              busy;
    logic              done;
    logic [ITER_W-1:0] iter_cnt;
`ifdef NODE_SEQ_PERF_EN
    logic [31:0]       perf_cyc;
`endif

    modport slave (
        input  start, abort, iter_limit, shift_req,
        output shift_ack, opt_run, dist_com_valid, dist_com_step, exp_init,
               exp_run, exp_fin, exch_run, exch_odd, distance_shift,
               exchange_shift_d, busy, done, iter_cnt
`ifdef NODE_SEQ_PERF_EN
        , output perf_cyc
`endif
    );

    modport master (
        output start, abort, iter_limit, shift_req,
        input  shift_ack, opt_run, dist_com_valid, dist_com_step, exp_init,
               exp_run, exp_fin, exch_run, exch_odd, distance_shift,
               exchange_shift_d, busy, done, iter_cnt
`ifdef NODE_SEQ_PERF_EN
        , input perf_cyc
`endif
    );
endinterface
`default_nettype wire

// File: rtl/node_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : node_sequencer                                                 |
// | Desc    : Annealing phase scheduler for the sub_node array; optional     |
// |           busy-cycle counter enabled by NODE_SEQ_PERF_EN.                |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
module node_sequencer #(
    parameter int ITER_W    = 24,
    parameter int DIST_CYC  = 4,
    parameter int EXP_CYC   = 17,
    parameter int EXCH_CYC  = 8,
    parameter int SHIFT_CYC = 32
) (
    input  wire logic       clk,
    input  wire logic       reset,
    node_sequencer_if.slave bus
);
    localparam int C_MAX_DE  = (DIST_CYC > EXP_CYC) ? DIST_CYC : EXP_CYC;
    localparam int C_MAX_XS  = (EXCH_CYC > SHIFT_CYC) ? EXCH_CYC : SHIFT_CYC;
    localparam int C_MAX_CYC = (C_MAX_DE > C_MAX_XS) ? C_MAX_DE : C_MAX_XS;
    localparam int PH_W      = $clog2(C_MAX_CYC) + 1;

    localparam logic [PH_W-1:0] C_DIST_LAST  = PH_W'(DIST_CYC - 1);
    localparam logic [PH_W-1:0] C_EXP_LAST   = PH_W'(EXP_CYC - 1);
    localparam logic [PH_W-1:0] C_EXCH_LAST  = PH_W'(EXCH_CYC - 1);
    localparam logic [PH_W-1:0] C_SHIFT_LAST = PH_W'(SHIFT_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_OPT   = 4'd1,
        S_DIST  = 4'd2,
        S_EXP_I = 4'd3,
        S_EXP_R = 4'd4,
        S_EXP_F = 4'd5,
        S_EXCH  = 4'd6,
        S_WAIT  = 4'd7,
        S_SHIFT = 4'd8
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PH_W-1:0]   r_phase;
    logic [ITER_W-1:0] r_limit;
    logic              r_abort;
    logic              r_from_idle;
    logic              w_start_acc;
    logic              w_wait_end;
    logic              w_done;
    logic              w_abort_any;
    logic [ITER_W-1:0] w_cnt_inc;

    assign w_cnt_inc   = (bus.iter_cnt == '1) ? bus.iter_cnt : bus.iter_cnt + ITER_W'(1);
    assign w_abort_any = r_abort | (bus.abort & bus.busy);

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_wait_end  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_start_acc = 1'b1;
                    if (bus.iter_limit == '0) w_done      = 1'b1;
                    else                      w_state_nxt = S_OPT;
                end else if (bus.shift_req && !bus.shift_ack) begin
                    // The ack cycle still sees the old request level; don't re-enter.
                    w_state_nxt = S_SHIFT;
                end
            end
            S_OPT:   w_state_nxt = S_DIST;
            S_DIST:  if (r_phase == C_DIST_LAST) w_state_nxt = S_EXP_I;
            S_EXP_I: w_state_nxt = S_EXP_R;
            S_EXP_R: if (r_phase == C_EXP_LAST) w_state_nxt = S_EXP_F;
            S_EXP_F: w_state_nxt = S_EXCH;
            S_EXCH:  w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (r_phase == C_EXCH_LAST) begin
                    w_wait_end = 1'b1;
                    if (bus.shift_req) begin
                        w_state_nxt = S_SHIFT;
                    end else if ((w_cnt_inc == r_limit) || w_abort_any) begin
                        w_state_nxt = S_IDLE;
                        w_done      = 1'b1;
                    end else begin
                        w_state_nxt = S_OPT;
                    end
                end
            end
            S_SHIFT: begin
                if (r_phase == C_SHIFT_LAST) begin
                    if (r_from_idle) begin
                        w_state_nxt = S_IDLE;
                    end else if ((bus.iter_cnt == r_limit) || w_abort_any) begin
                        w_state_nxt = S_IDLE;
                        w_done      = 1'b1;
                    end else begin
                        w_state_nxt = S_OPT;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state              <= S_IDLE;
            r_phase              <= '0;
            r_limit              <= '0;
            r_abort              <= 1'b0;
            r_from_idle          <= 1'b0;
            bus.shift_ack        <= 1'b0;
            bus.opt_run          <= 1'b0;
            bus.dist_com_valid   <= 1'b0;
            bus.dist_com_step    <= 2'd0;
            bus.exp_init         <= 1'b0;
            bus.exp_run          <= 1'b0;
            bus.exp_fin          <= 1'b0;
            bus.exch_run         <= 1'b0;
            bus.exch_odd         <= 1'b0;
            bus.distance_shift   <= 1'b0;
            bus.exchange_shift_d <= 1'b0;
            bus.busy             <= 1'b0;
            bus.done             <= 1'b0;
            bus.iter_cnt         <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= ((w_state_nxt == r_state) && (r_state != S_IDLE)) ? r_phase + PH_W'(1) : '0;

            bus.opt_run          <= (w_state_nxt == S_OPT);
            bus.dist_com_valid   <= (w_state_nxt == S_DIST);
            bus.dist_com_step    <= ((w_state_nxt == S_DIST) && (r_state == S_DIST)) ?
                                    bus.dist_com_step + 2'd1 : 2'd0;
            bus.exp_init         <= (w_state_nxt == S_EXP_I);
            bus.exp_run          <= (w_state_nxt == S_EXP_R);
            bus.exp_fin          <= (w_state_nxt == S_EXP_F);
            bus.exch_run         <= (w_state_nxt == S_EXCH);
            bus.distance_shift   <= (w_state_nxt == S_SHIFT);
            bus.exchange_shift_d <= bus.distance_shift;
            bus.shift_ack        <= (r_state == S_SHIFT) && (w_state_nxt != S_SHIFT);
            bus.done             <= w_done;

            if (w_start_acc) begin
                r_limit      <= bus.iter_limit;
                bus.iter_cnt <= '0;
                bus.exch_odd <= 1'b0;
            end else if (w_wait_end) begin
                bus.iter_cnt <= w_cnt_inc;
                bus.exch_odd <= ~bus.exch_odd;
            end

            if (w_start_acc && (bus.iter_limit != '0)) bus.busy <= 1'b1;
            else if (w_state_nxt == S_IDLE)             bus.busy <= 1'b0;

            if (w_start_acc || (w_state_nxt == S_IDLE)) r_abort <= 1'b0;
            else if (bus.abort && bus.busy)             r_abort <= 1'b1;

            if ((w_state_nxt == S_SHIFT) && (r_state != S_SHIFT))
                r_from_idle <= (r_state == S_IDLE);
        end
    end

`ifdef NODE_SEQ_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           bus.perf_cyc <= 32'd0;
        else if (w_start_acc) bus.perf_cyc <= 32'd0;
        else if (bus.busy)    bus.perf_cyc <= bus.perf_cyc + 32'd1;
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_node_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_node_sequencer                                              |
// | Desc    : Cycle-checked bench for node_sequencer against an offset-based |
// |           iteration schedule model; directed scenarios then random.      |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_node_sequencer;
    localparam int ITER_W    = 24;
    localparam int DIST_CYC  = 4;
    localparam int EXP_CYC   = 17;
    localparam int EXCH_CYC  = 8;
    localparam int SHIFT_CYC = 32;
    localparam int ITER_LEN  = 4 + DIST_CYC + EXP_CYC + EXCH_CYC;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    node_sequencer_if #(.ITER_W(ITER_W)) bus ();

    node_sequencer #(
        .ITER_W(ITER_W), .DIST_CYC(DIST_CYC), .EXP_CYC(EXP_CYC),
        .EXCH_CYC(EXCH_CYC), .SHIFT_CYC(SHIFT_CYC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_opt = 0;
    int n_done = 0;
    int n_ack = 0;

    // Reference: position is IDLE, an offset inside a 33-cycle iteration, or a shift slot.
    int                m_mode;      // 0 idle, 1 iteration, 2 shift
    int                m_off;
    logic [ITER_W-1:0] m_cnt, m_limit;
    bit                m_odd, m_busy, m_abort, m_from_idle;
    bit                e_done, e_ack, e_ds, e_xsd;
    logic [31:0]       m_perf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_off = 0; m_cnt = '0; m_limit = '0;
        m_odd = 0; m_busy = 0; m_abort = 0; m_from_idle = 0;
        e_done = 0; e_ack = 0; e_ds = 0; e_xsd = 0; m_perf = 32'd0;
    endtask

    task automatic decide(input bit allow_shift);
        if (allow_shift && bus.shift_req) begin
            m_mode = 2; m_off = 0; m_from_idle = 0;
        end else if ((m_cnt == m_limit) || m_abort) begin
            m_mode = 0; e_done = 1; m_busy = 0; m_abort = 0;
        end else begin
            m_mode = 1; m_off = 0;
        end
    endtask

    task automatic model_step();
        bit prev_ack, prev_ds;
        if (!reset) begin
            model_reset();
            return;
        end
        prev_ack = e_ack;
        prev_ds  = e_ds;
        e_done = 0; e_ack = 0;
        if (m_busy) m_perf = m_perf + 32'd1;
        case (m_mode)
            0: begin
                if (bus.start) begin
                    m_cnt = '0; m_odd = 0; m_abort = 0; m_limit = bus.iter_limit; m_perf = 32'd0;
                    if (bus.iter_limit == '0) e_done = 1;
                    else begin m_mode = 1; m_off = 0; m_busy = 1; end
                end else if (bus.shift_req && !prev_ack) begin
                    m_mode = 2; m_off = 0; m_from_idle = 1;
                end
            end
            1: begin
                if (bus.abort) m_abort = 1;
                if (m_off < ITER_LEN - 1) m_off++;
                else begin
                    if (m_cnt != '1) m_cnt = m_cnt + 1;
                    m_odd = ~m_odd;
                    decide(1);
                end
            end
            default: begin
                if (bus.abort && m_busy) m_abort = 1;
                if (m_off < SHIFT_CYC - 1) m_off++;
                else begin
                    e_ack = 1;
                    if (m_from_idle) m_mode = 0;
                    else decide(0);
                end
            end
        endcase
        e_ds  = (m_mode == 2);
        e_xsd = prev_ds;
    endtask

    task automatic compare_all();
        bit it;
        logic [13:0] exp_v, obs_v;
        logic [1:0]  step;
        it   = (m_mode == 1);
        step = (it && m_off >= 1 && m_off <= DIST_CYC) ? 2'((m_off - 1) % 4) : 2'd0;
        exp_v = {it && m_off == 0,
                 it && m_off >= 1 && m_off <= DIST_CYC,
                 step,
                 it && m_off == DIST_CYC + 1,
                 it && m_off >= DIST_CYC + 2 && m_off <= DIST_CYC + 1 + EXP_CYC,
                 it && m_off == DIST_CYC + 2 + EXP_CYC,
                 it && m_off == DIST_CYC + 3 + EXP_CYC,
                 m_odd, e_ds, e_xsd, e_ack, m_busy, e_done};
        obs_v = {bus.opt_run, bus.dist_com_valid, bus.dist_com_step, bus.exp_init,
                 bus.exp_run, bus.exp_fin, bus.exch_run, bus.exch_odd, bus.distance_shift,
                 bus.exchange_shift_d, bus.shift_ack, bus.busy, bus.done};
        check("outputs", 64'(obs_v), 64'(exp_v));
        check("iter_cnt", 64'(bus.iter_cnt), 64'(m_cnt));
`ifdef NODE_SEQ_PERF_EN
        check("perf_cyc", 64'(bus.perf_cyc), 64'(m_perf));
`endif
    endtask

    // One clock: inputs already driven at the preceding negedge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (bus.opt_run === 1'b1) n_opt++;
        if (bus.done === 1'b1) n_done++;
        if (bus.shift_ack === 1'b1) n_ack++;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        if (bus.shift_ack === 1'b1) bus.shift_req = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_start(input int limit);
        bus.start      = 1'b1;
        bus.iter_limit = ITER_W'(limit);
    endtask

    initial begin
        int o0, d0, a0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.shift_req = 1'b0; bus.iter_limit = '0;
        model_reset();
        #2;
        compare_all();
        run(3);
        reset = 1'b1;
        run(2);

        // Single iteration.
        o0 = n_opt; d0 = n_done;
        do_start(1);
        run(ITER_LEN + 4);
        check("lim1_opt_count", 64'(n_opt - o0), 64'd1);
        check("lim1_done_count", 64'(n_done - d0), 64'd1);
        check("lim1_iter_cnt", 64'(bus.iter_cnt), 64'd1);

        // Three iterations, exch_odd alternates.
        o0 = n_opt; d0 = n_done;
        do_start(3);
        run(3 * ITER_LEN + 4);
        check("lim3_opt_count", 64'(n_opt - o0), 64'd3);
        check("lim3_done_count", 64'(n_done - d0), 64'd1);

        // Shift requested during iteration 2 of 4.
        o0 = n_opt; a0 = n_ack;
        do_start(4);
        run(ITER_LEN + 10);
        bus.shift_req = 1'b1;
        run(3 * ITER_LEN + SHIFT_CYC + 6);
        check("shift_ack_count", 64'(n_ack - a0), 64'd1);
        check("shift_opt_count", 64'(n_opt - o0), 64'd4);

        // Abort during EXP_R of iteration 1.
        o0 = n_opt;
        do_start(10);
        run(12);
        bus.abort = 1'b1;
        run(ITER_LEN + 10);
        check("abort_opt_count", 64'(n_opt - o0), 64'd1);
        check("abort_iter_cnt", 64'(bus.iter_cnt), 64'd1);

        // Zero limit, then start while busy.
        o0 = n_opt; d0 = n_done;
        do_start(0);
        run(3);
        check("lim0_done_count", 64'(n_done - d0), 64'd1);
        check("lim0_opt_count", 64'(n_opt - o0), 64'd0);
        o0 = n_opt;
        do_start(2);
        run(5);
        do_start(7);
        run(2 * ITER_LEN + 6);
        check("busy_start_opt_count", 64'(n_opt - o0), 64'd2);

        // Shift from idle.
        a0 = n_ack;
        bus.shift_req = 1'b1;
        run(SHIFT_CYC + 5);
        check("idle_shift_ack", 64'(n_ack - a0), 64'd1);

        // Asynchronous reset while in DIST.
        do_start(5);
        run(3);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_dist_valid", 64'(bus.dist_com_valid), 64'd0);
        @(negedge clk);
        run(2);
        reset = 1'b1;
        run(3);
        check("rst_busy", 64'(bus.busy), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bus.iter_limit = ITER_W'($urandom_range(0, 3));
            bus.start      = ($urandom_range(0, 39) == 0);
            bus.abort      = ($urandom_range(0, 79) == 0);
            if (!bus.shift_req && $urandom_range(0, 99) == 0) bus.shift_req = 1'b1;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
